jtag_ir: RTL and testbench
==========================

JTAG_IR -- requirements
Module: jtag_ir

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register length in bits (legal range 2..8).
REQ-002 SHALL have parameter IDCODE_OP, default 5'b00001, opcode loaded on reset and TAP reset.
REQ-003 SHALL have parameter SAMPLE_OP, default 5'b00010, SAMPLE/PRELOAD opcode.
REQ-004 SHALL have parameter EXTEST_OP, default 5'b00000, EXTEST opcode.
REQ-005 SHALL have port TCK  input  1  test clock; the only clock.
REQ-006 SHALL have port TRST  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port TDI  input  1  serial data in.
REQ-008 SHALL have port ir_capture  input  1  TAP in Capture-IR.
REQ-009 SHALL have port ir_shift  input  1  TAP in Shift-IR.
REQ-010 SHALL have port ir_update  input  1  TAP in Update-IR.
REQ-011 SHALL have port tap_reset  input  1  TAP in Test-Logic-Reset.
REQ-012 SHALL have port ir_status  input  IR_WIDTH-2  design status captured into the upper IR bits (used only with the configuration macro).
REQ-013 SHALL have port instr  output  IR_WIDTH  current (updated) instruction.
REQ-014 SHALL have ports sel_bypass, sel_idcode, sel_sample, sel_extest  output  1 each  one-hot decode of instr.
REQ-015 SHALL have port ir_tdo  output  1  serial data out.
REQ-016 SHALL have port ir_tdo_oe  output  1  ir_tdo valid/drive enable.

Function
REQ-017 Shift register sr[IR_WIDTH-1:0] SHALL update on rising TCK only.
REQ-018 On rising TCK with ir_capture=1, sr SHALL load {upper bits, 2'b01}; upper bits are zero unless the macro is defined.
REQ-019 On rising TCK with ir_shift=1 and ir_capture=0, sr SHALL shift right: sr <= {TDI, sr[IR_WIDTH-1:1]}.
REQ-020 When ir_capture and ir_shift are both high, capture SHALL take priority; with neither high, sr SHALL hold.
REQ-021 On rising TCK with ir_update=1, instr SHALL load sr; the new value is visible one cycle after the Update-IR edge.
REQ-022 On rising TCK with tap_reset=1, instr SHALL load IDCODE_OP; this overrides ir_update.
REQ-023 instr SHALL hold in all other states, including during shifting.
REQ-024 Decode SHALL be combinational from instr: sel_idcode for IDCODE_OP, sel_sample for SAMPLE_OP, sel_extest for EXTEST_OP, sel_bypass for all-ones and for every unassigned opcode.
REQ-025 Exactly one sel_* output SHALL be high at all times.
REQ-026 ir_tdo SHALL be registered on falling TCK from sr[0]; ir_tdo_oe SHALL be registered on falling TCK from ir_shift.
REQ-027 When ir_tdo_oe is low, ir_tdo SHALL hold its last value.
REQ-028 Shifting more than IR_WIDTH cycles SHALL be legal; the last IR_WIDTH TDI bits are retained.

Reset
REQ-029 TRST low SHALL asynchronously set sr to {0..0,2'b01}, instr to IDCODE_OP, ir_tdo to 0, and ir_tdo_oe to 0.
REQ-030 TRST low mid-shift SHALL discard the partial shift and leave sel_idcode=1.
REQ-031 Release of TRST SHALL take effect on the next TCK edge of the respective polarity.

Configuration
REQ-032 When macro IR_CAPTURE_STATUS_EN is defined, Capture-IR SHALL load {ir_status, 2'b01}.
REQ-033 When IR_CAPTURE_STATUS_EN is undefined, Capture-IR SHALL load {0..0, 2'b01}, and ir_status SHALL be ignored.

Verification (IR_WIDTH=5)
REQ-034 Assert TRST low -> instr=00001, sel_idcode=1, ir_tdo=0, ir_tdo_oe=0.
REQ-035 Capture, then 5 shifts with TDI=1,1,1,1,1, then update -> ir_tdo sequence 1,0,0,0,0 and instr=11111 with sel_bypass=1.
REQ-036 Shift in TDI=0,1,0,0,0 (LSB first), then update -> instr=00010, sel_sample=1; instr unchanged until the update edge.
REQ-037 Shift in opcode 10101, then update -> instr=10101, sel_bypass=1; then assert tap_reset for one cycle -> instr=00001.
REQ-038 Drive TRST low after 3 of 5 shifts -> instr=00001 immediately; a subsequent capture/shift restarts cleanly.
REQ-039 With IR_CAPTURE_STATUS_EN and ir_status=3'b101, capture then 5 shifts -> ir_tdo sequence 1,0,1,0,1.

Source files
------------

// File: rtl/jtag_ir.sv
// ----------------------------------------------------------------------------
// jtag_ir : JTAG TAP instruction register with capture/shift/update and decode.
// Optional: define IR_CAPTURE_STATUS_EN to capture ir_status into the upper bits.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_ir #(
  parameter int unsigned           IR_WIDTH  = 5,
  parameter logic [IR_WIDTH-1:0]   IDCODE_OP = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]   SAMPLE_OP = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0]   EXTEST_OP = IR_WIDTH'(0)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic                ir_capture,
  input  logic                ir_shift,
  input  logic                ir_update,
  input  logic                tap_reset,
  input  logic [IR_WIDTH-3:0] ir_status,
  output logic [IR_WIDTH-1:0] instr,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic                sel_sample,
  output logic                sel_extest,
  output logic                ir_tdo,
  output logic                ir_tdo_oe
);

  // The two LSBs of a captured IR are fixed at 2'b01 by IEEE 1149.1.
  localparam logic [IR_WIDTH-1:0] c_SR_RESET = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] sr_q, sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                tdo_q, tdo_d;
  logic                tdo_oe_q, tdo_oe_d;
  logic [IR_WIDTH-1:0] w_capture_val;

`ifdef IR_CAPTURE_STATUS_EN
  assign w_capture_val = {ir_status, 2'b01};
`else
  logic unused_status;
  assign unused_status = ^ir_status;
  assign w_capture_val = c_SR_RESET;
`endif

  always_comb begin
    sr_d = sr_q;
    if (ir_capture) begin
      sr_d = w_capture_val;
    end else if (ir_shift) begin
      sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
    end
  end

  always_comb begin
    instr_d = instr_q;
    if (tap_reset) begin
      instr_d = IDCODE_OP;
    end else if (ir_update) begin
      instr_d = sr_q;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr_q    <= c_SR_RESET;
      instr_q <= IDCODE_OP;
    end else begin
      sr_q    <= sr_d;
      instr_q <= instr_d;
    end
  end

  // TDO launches on the falling edge so the TAP partner can sample on rising TCK.
  always_comb begin
    tdo_d    = tdo_q;
    tdo_oe_d = ir_shift;
    if (ir_shift) begin
      tdo_d = sr_q[0];
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  // Priority chain keeps the selects one-hot even if opcodes were configured to collide.
  always_comb begin
    sel_bypass = 1'b0;
    sel_idcode = 1'b0;
    sel_sample = 1'b0;
    sel_extest = 1'b0;
    if (instr_q == IDCODE_OP) begin
      sel_idcode = 1'b1;
    end else if (instr_q == SAMPLE_OP) begin
      sel_sample = 1'b1;
    end else if (instr_q == EXTEST_OP) begin
      sel_extest = 1'b1;
    end else begin
      sel_bypass = 1'b1;
    end
  end

  assign instr     = instr_q;
  assign ir_tdo    = tdo_q;
  assign ir_tdo_oe = tdo_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_ir.sv
// ----------------------------------------------------------------------------
// tb_jtag_ir : directed plus randomized checks of jtag_ir against a queue model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtag_ir;

  localparam int W = 5;

  logic         TCK = 1'b0;
  logic         TRST = 1'b0;
  logic         TDI = 1'b0;
  logic         ir_capture = 1'b0;
  logic         ir_shift = 1'b0;
  logic         ir_update = 1'b0;
  logic         tap_reset = 1'b0;
  logic [W-3:0] ir_status = '0;
  logic [W-1:0] instr;
  logic         sel_bypass, sel_idcode, sel_sample, sel_extest;
  logic         ir_tdo, ir_tdo_oe;

  jtag_ir dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TDI        (TDI),
    .ir_capture (ir_capture),
    .ir_shift   (ir_shift),
    .ir_update  (ir_update),
    .tap_reset  (tap_reset),
    .ir_status  (ir_status),
    .instr      (instr),
    .sel_bypass (sel_bypass),
    .sel_idcode (sel_idcode),
    .sel_sample (sel_sample),
    .sel_extest (sel_extest),
    .ir_tdo     (ir_tdo),
    .ir_tdo_oe  (ir_tdo_oe)
  );

  always #5 TCK = ~TCK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: IR contents as a bit queue, element 0 is the bit nearest TDO.
  bit       q[$];
  int       m_instr;
  bit       m_tdo;
  bit       m_oe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pack_q();
    int v = 0;
    for (int i = 0; i < W; i++) v += int'(q[i]) << i;
    return v;
  endfunction

  // {bypass, idcode, sample, extest}
  function automatic logic [3:0] exp_sel(input int v);
    case (v)
      1:       return 4'b0100;
      2:       return 4'b0010;
      0:       return 4'b0001;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(1'b1);
    for (int i = 1; i < W; i++) q.push_back(1'b0);
    m_instr = 1;
    m_tdo   = 1'b0;
    m_oe    = 1'b0;
  endtask

  task automatic model_capture();
    q.delete();
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 0; i < W - 2; i++) begin
`ifdef IR_CAPTURE_STATUS_EN
      q.push_back(ir_status[i]);
`else
      q.push_back(1'b0);
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_instr"}, 32'(instr), 32'(m_instr));
    chk({tag, "_sel"}, 32'({sel_bypass, sel_idcode, sel_sample, sel_extest}), 32'(exp_sel(m_instr)));
    chk({tag, "_onehot"}, 32'($countones({sel_bypass, sel_idcode, sel_sample, sel_extest})), 32'd1);
  endtask

  // Called at posedge+1; drives one TCK cycle of controls and checks both edges.
  task automatic tick(input logic cap, input logic sh, input logic upd, input logic tr, input logic d);
    ir_capture = cap; ir_shift = sh; ir_update = upd; tap_reset = tr; TDI = d;
    @(negedge TCK); #1;
    if (sh) begin
      m_tdo = q[0];
      m_oe  = 1'b1;
    end else begin
      m_oe  = 1'b0;
    end
    chk("tdo", 32'(ir_tdo), 32'(m_tdo));
    chk("tdo_oe", 32'(ir_tdo_oe), 32'(m_oe));
    @(posedge TCK); #1;
    if (tr) m_instr = 1;
    else if (upd) m_instr = pack_q();
    if (cap) model_capture();
    else if (sh) begin
      void'(q.pop_front());
      q.push_back(d);
    end
    check_outputs("cyc");
  endtask

  task automatic shift_in(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, v[i]);
  endtask

  // Asynchronous TRST pulse entirely between clock edges.
  task automatic pulse_trst();
    #1 TRST = 1'b0;
    #1;
    model_reset();
    check_outputs("trst");
    chk("trst_tdo", 32'(ir_tdo), 32'd0);
    chk("trst_oe", 32'(ir_tdo_oe), 32'd0);
    chk("trst_idcode", 32'(sel_idcode), 32'd1);
    #1 TRST = 1'b1;
  endtask

  initial begin
    model_reset();
    ir_status = 3'b101;
    #12;
    chk("rst_instr", 32'(instr), 32'h01);
    chk("rst_idcode", 32'(sel_idcode), 32'd1);
    chk("rst_tdo", 32'(ir_tdo), 32'd0);
    chk("rst_oe", 32'(ir_tdo_oe), 32'd0);
    @(posedge TCK); #1;
    TRST = 1'b1;

    // Capture, shift five ones, update: BYPASS.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef IR_CAPTURE_STATUS_EN
      chk("tdo_seq_st", 32'(ir_tdo), 32'((5'b10101 >> i) & 1));
`else
      chk("tdo_seq", 32'(ir_tdo), (i == 0) ? 32'd1 : 32'd0);
`endif
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ones_instr", 32'(instr), 32'h1F);
    chk("ones_bypass", 32'(sel_bypass), 32'd1);

    // SAMPLE opcode shifted LSB first.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_in(5'b00010);
    chk("pre_upd_instr", 32'(instr), 32'h1F);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sample_instr", 32'(instr), 32'h02);
    chk("sample_sel", 32'(sel_sample), 32'd1);

    // Unassigned opcode, then TAP reset also overriding a concurrent update.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_in(5'b10101);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("unasg_instr", 32'(instr), 32'h15);
    chk("unasg_bypass", 32'(sel_bypass), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("tapreset_instr", 32'(instr), 32'h01);

    // EXTEST, then TRST after 3 of 5 shifts, then clean restart.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_in(5'b00000);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("extest_sel", 32'(sel_extest), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_trst();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    shift_in(5'b00010);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_instr", 32'(instr), 32'h02);

    // Over-length shift keeps only the last W bits.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_in(5'b11011);
    shift_in(5'b00001);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("overlen_instr", 32'(instr), 32'h01);

    for (int n = 0; n < 400; n++) begin
      ir_status = 3'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_trst();
      else tick(($urandom_range(0, 5) == 0), 1'($urandom), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 24) == 0), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
